// File: rtl/membus_arb_pkg.sv
// Shared types for the Membus arbiter: source tags and sizing limits.
// No logic; imported by the arbiter top and its tag FIFO.
package membus_arb_pkg;

  typedef enum logic {SRC_CPU, SRC_DMA} src_t;

  localparam int MAX_OUT_LIMIT = 8;

endpackage

// File: rtl/membus_if.sv
// Membus request/response bundle; master drives requests, slave drives ready and responses.
// Responses carry no tag, so they must return in issue order.
interface Membus #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            valid;
  logic            ready;
  logic [AW-1:0]   addr;
  logic            wen;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wmask;
  logic            rvalid;
  logic [DW-1:0]   rdata;

  modport master (output valid, addr, wen, wdata, wmask, input ready, rvalid, rdata);
  modport slave  (input valid, addr, wen, wdata, wmask, output ready, rvalid, rdata);
endinterface

// File: rtl/arb_tag_fifo.sv
// In-order FIFO of source tags for outstanding requests; registered head, count, full and empty.
// Push is ignored when full and pop when empty; simultaneous push/pop keeps the count.
module arb_tag_fifo
  import membus_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  src_t                       din,
  input  logic                       pop,
  output src_t                       head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  src_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap at DEPTH, which need not be a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/membus_arbiter_pipe.sv
// CPU/DMA Membus arbiter, fixed CPU priority, up to MAX_OUT requests in flight; ARB_STARVE_GUARD_EN adds a DMA starvation guard.
// Zero-latency grant and response routing; issue stalls while the tag FIFO is full, and a backpressured source stays locked until it fires.
module membus_arbiter_pipe
  import membus_arb_pkg::*;
#(
  parameter int MAX_OUT      = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic  clk,
  input  logic  rst,
  Membus.slave  cpu,
  Membus.slave  dma,
  Membus.master out,
  output logic  spurious
);
  localparam int CW = $clog2(MAX_OUT + 1);

  logic          lock;
  src_t          lock_src;
  src_t          sel_src;
  logic          sel_vld;
  logic          dma_pri;
  logic          issue_ok;
  logic          fire;
  logic          pop;
  logic          full;
  logic          empty;
  src_t          head;
  logic [CW-1:0] tag_count;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   starve_cnt <= '0;
    else if (fire && sel_src == SRC_DMA)       starve_cnt <= '0;
    else if (dma.valid && starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
  end

  assign dma_pri = (starve_cnt == STARVE_MAX);
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign dma_pri = 1'b0;
`endif

  always_comb begin
    sel_src = SRC_CPU;
    if (lock)                                   sel_src = lock_src;
    else if (dma.valid && (dma_pri || !cpu.valid)) sel_src = SRC_DMA;
    sel_vld = (sel_src == SRC_DMA) ? dma.valid : cpu.valid;
  end

  // Full is taken from the registered count, so a same-cycle pop cannot open issue.
  assign issue_ok = sel_vld & ~full & ~rst;
  assign fire     = issue_ok & out.ready;
  assign pop      = out.rvalid & ~empty & ~rst;

  always_comb begin
    out.valid = issue_ok;
    out.addr  = '0;
    out.wen   = 1'b0;
    out.wdata = '0;
    out.wmask = '0;
    cpu.ready = 1'b0;
    dma.ready = 1'b0;
    if (sel_vld && sel_src == SRC_CPU) begin
      out.addr  = cpu.addr;
      out.wen   = cpu.wen;
      out.wdata = cpu.wdata;
      out.wmask = cpu.wmask;
      cpu.ready = issue_ok & out.ready;
    end else if (sel_vld) begin
      out.addr  = dma.addr;
      out.wen   = dma.wen;
      out.wdata = dma.wdata;
      out.wmask = dma.wmask;
      dma.ready = issue_ok & out.ready;
    end
  end

  always_comb begin
    cpu.rvalid = pop & (head == SRC_CPU);
    dma.rvalid = pop & (head == SRC_DMA);
    cpu.rdata  = (pop && head == SRC_CPU) ? out.rdata : '0;
    dma.rdata  = (pop && head == SRC_DMA) ? out.rdata : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock     <= 1'b0;
      lock_src <= SRC_CPU;
    end else if (fire) begin
      lock     <= 1'b0;
    end else if (issue_ok && !out.ready) begin
      lock     <= 1'b1;
      lock_src <= sel_src;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             spurious <= 1'b0;
    else if (out.rvalid && tag_count == '0) spurious <= 1'b1;
  end

  arb_tag_fifo #(
    .DEPTH (MAX_OUT)
  ) u_tags (
    .clk   (clk),
    .rst   (rst),
    .push  (fire),
    .din   (sel_src),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (tag_count)
  );

endmodule

// File: tb/tb_membus_arbiter_pipe.sv
// Directed bench for membus_arbiter_pipe: a monitor scores issues and responses against queues
// filled by the stimulus process; direct checks cover grants, blocking, spurious and reset.
module tb_membus_arbiter_pipe;
  import membus_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spurious;

  Membus cpu_if ();
  Membus dma_if ();
  Membus out_if ();

  always #5 clk = ~clk;

  membus_arbiter_pipe #(
    .MAX_OUT      (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu      (cpu_if),
    .dma      (dma_if),
    .out      (out_if),
    .spurious (spurious)
  );

  typedef struct {
    bit          is_dma;
    logic [31:0] data;
  } rsp_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_iss [$];
  rsp_t        exp_rsp [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_cpu(input logic v, input logic [31:0] a);
    cpu_if.valid = v; cpu_if.addr = a; cpu_if.wen = 1'b0; cpu_if.wdata = '0; cpu_if.wmask = '0;
  endtask

  task automatic drv_dma(input logic v, input logic [31:0] a);
    dma_if.valid = v; dma_if.addr = a; dma_if.wen = 1'b0; dma_if.wdata = '0; dma_if.wmask = '0;
  endtask

  task automatic drv_rsp(input logic v, input logic [31:0] d);
    out_if.rvalid = v; out_if.rdata = d;
  endtask

  task automatic expect_req(input logic [31:0] a, input bit is_dma, input logic [31:0] d);
    rsp_t r;
    r.is_dma = is_dma;
    r.data   = d;
    exp_iss.push_back(a);
    exp_rsp.push_back(r);
  endtask

  // Scoreboard monitor: every fire and every routed response is compared in order.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_if.valid && out_if.ready) begin
        if (exp_iss.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL issue_unexpected: got addr %h expected no issue", out_if.addr);
        end else begin
          chk("issue_addr", out_if.addr, exp_iss.pop_front());
        end
      end
      if (cpu_if.rvalid || dma_if.rvalid) begin
        if (exp_rsp.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rsp_unexpected: got cpu_rv %b dma_rv %b expected none", cpu_if.rvalid, dma_if.rvalid);
        end else begin
          rsp_t e;
          e = exp_rsp.pop_front();
          chk("rsp_cpu_rvalid", {31'd0, cpu_if.rvalid}, {31'd0, !e.is_dma});
          chk("rsp_dma_rvalid", {31'd0, dma_if.rvalid}, {31'd0, e.is_dma});
          chk("rsp_cpu_rdata", cpu_if.rdata, e.is_dma ? 32'd0 : e.data);
          chk("rsp_dma_rdata", dma_if.rdata, e.is_dma ? e.data : 32'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: active requests and a response must all be masked.
    drv_cpu(1'b1, 32'h10); drv_dma(1'b1, 32'h200);
    out_if.ready = 1'b1; drv_rsp(1'b1, 32'h1);
    @(negedge clk);
    chk("rst_out_valid", out_if.valid, 0);
    chk("rst_cpu_ready", cpu_if.ready, 0);
    chk("rst_dma_ready", dma_if.ready, 0);
    chk("rst_cpu_rvalid", cpu_if.rvalid, 0);
    chk("rst_dma_rvalid", dma_if.rvalid, 0);
    chk("rst_spurious", spurious, 0);
    step();
    rst = 1'b0; drv_cpu(1'b0, 0); drv_dma(1'b0, 0); drv_rsp(1'b0, 0);
    step();

    // Contention: CPU wins twice, DMA blocked while CPU is valid and while full.
    drv_cpu(1'b1, 32'h10); drv_dma(1'b1, 32'h200);
    cpu_if.wen = 1'b1; cpu_if.wdata = 32'hCAFE_0001; cpu_if.wmask = 4'hF;
    expect_req(32'h10, 1'b0, 32'hDEADBEEF);
    @(negedge clk);
    chk("cont_cpu_ready", cpu_if.ready, 1);
    chk("cont_dma_ready", dma_if.ready, 0);
    chk("cont_wdata", out_if.wdata, 32'hCAFE_0001);
    chk("cont_wen", out_if.wen, 1);
    step();
    drv_cpu(1'b1, 32'h14);
    expect_req(32'h14, 1'b0, 32'h0000_1414);
    step();
    drv_rsp(1'b1, 32'hDEADBEEF);
    @(negedge clk);
    chk("full_out_valid", out_if.valid, 0);
    chk("full_cpu_ready", cpu_if.ready, 0);
    chk("full_dma_ready", dma_if.ready, 0);
    step();
    drv_cpu(1'b0, 0); drv_rsp(1'b1, 32'h0000_1414);
    expect_req(32'h200, 1'b1, 32'h0000_2000);
    step();
    drv_dma(1'b0, 0); drv_rsp(1'b1, 32'h0000_2000);
    step();
    drv_rsp(1'b0, 0);
    step();

    // Lock: DMA backpressured for 3 cycles, CPU arrives meanwhile.
    out_if.ready = 1'b0; drv_dma(1'b1, 32'h100);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) drv_cpu(1'b1, 32'h20);
      @(negedge clk);
      chk("lock_addr", out_if.addr, 32'h100);
      chk("lock_cpu_ready", cpu_if.ready, 0);
      step();
    end
    out_if.ready = 1'b1;
    expect_req(32'h100, 1'b1, 32'h1);
    @(negedge clk);
    chk("lock_dma_ready", dma_if.ready, 1);
    step();
    drv_dma(1'b0, 0);
    expect_req(32'h20, 1'b0, 32'h2);
    @(negedge clk);
    chk("after_lock_addr", out_if.addr, 32'h20);
    step();
    drv_cpu(1'b0, 0); drv_rsp(1'b1, 32'h1);
    step();
    drv_rsp(1'b1, 32'h2);
    step();
    drv_rsp(1'b0, 0);
    step();

    // Pipelining with RAM latency 2; third request waits until after the first pop.
    drv_cpu(1'b1, 32'h30);
    expect_req(32'h30, 1'b0, 32'hA);
    step();
    drv_cpu(1'b0, 0); drv_dma(1'b1, 32'h300);
    expect_req(32'h300, 1'b1, 32'hB);
    step();
    drv_dma(1'b0, 0); drv_cpu(1'b1, 32'h34); drv_rsp(1'b1, 32'hA);
    @(negedge clk);
    chk("pipe_blocked_valid", out_if.valid, 0);
    chk("pipe_blocked_ready", cpu_if.ready, 0);
    step();
    drv_rsp(1'b1, 32'hB);
    expect_req(32'h34, 1'b0, 32'hC);
    @(negedge clk);
    chk("pipe_third_ready", cpu_if.ready, 1);
    step();
    drv_cpu(1'b0, 0); drv_rsp(1'b1, 32'hC);
    step();
    drv_rsp(1'b0, 0);
    step();

`ifdef ARB_STARVE_GUARD_EN
    // Starvation guard with STARVE_LIMIT = 4: DMA wins on cycle 4.
    for (int c = 0; c < 6; c++) begin
      drv_cpu(1'b1, 32'h50 + 32'(4 * c));
      drv_dma(1'b1, (c == 5) ? 32'h504 : 32'h500);
      if (c == 4) expect_req(32'h500, 1'b1, 32'h5000 + 32'(c));
      else        expect_req(32'h50 + 32'(4 * c), 1'b0, 32'h5000 + 32'(c));
      if (c >= 1) drv_rsp(1'b1, 32'h5000 + 32'(c - 1));
      @(negedge clk);
      chk("starve_dma_ready", dma_if.ready, (c == 4) ? 1 : 0);
      chk("starve_cpu_ready", cpu_if.ready, (c == 4) ? 0 : 1);
      step();
    end
    drv_cpu(1'b0, 0);
    expect_req(32'h504, 1'b1, 32'h5006);
    drv_rsp(1'b1, 32'h5005);
    step();
    drv_dma(1'b0, 0); drv_rsp(1'b1, 32'h5006);
    step();
    drv_rsp(1'b0, 0);
    step();
`endif

    // Spurious response with nothing outstanding.
    @(negedge clk);
    chk("spur_before", spurious, 0);
    step();
    drv_rsp(1'b1, 32'hBAD);
    @(negedge clk);
    chk("spur_cpu_rvalid", cpu_if.rvalid, 0);
    chk("spur_dma_rvalid", dma_if.rvalid, 0);
    step();
    drv_rsp(1'b0, 0);
    @(negedge clk);
    chk("spur_set", spurious, 1);
    step(); step();
    @(negedge clk);
    chk("spur_sticky", spurious, 1);
    step();

    // Reset with two requests in flight.
    drv_cpu(1'b1, 32'h40);
    exp_iss.push_back(32'h40);
    step();
    drv_cpu(1'b0, 0); drv_dma(1'b1, 32'h400);
    exp_iss.push_back(32'h400);
    step();
    rst = 1'b1; drv_cpu(1'b1, 32'h44); drv_rsp(1'b1, 32'h99);
    @(negedge clk);
    chk("midrst_out_valid", out_if.valid, 0);
    chk("midrst_cpu_ready", cpu_if.ready, 0);
    chk("midrst_dma_ready", dma_if.ready, 0);
    chk("midrst_cpu_rvalid", cpu_if.rvalid, 0);
    chk("midrst_dma_rvalid", dma_if.rvalid, 0);
    chk("midrst_spurious", spurious, 0);
    step();
    rst = 1'b0; drv_dma(1'b0, 0); drv_rsp(1'b0, 0);
    expect_req(32'h44, 1'b0, 32'h44D);
    @(negedge clk);
    chk("postrst_cpu_ready", cpu_if.ready, 1);
    step();
    drv_cpu(1'b0, 0); drv_rsp(1'b1, 32'h44D);
    step();
    drv_rsp(1'b0, 0);
    step(); step();
    @(negedge clk);
    chk("iss_queue_drained", exp_iss.size(), 0);
    chk("rsp_queue_drained", exp_rsp.size(), 0);
    chk("final_spurious", spurious, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/membus_arbiter_pipe.md
# membus_arbiter_pipe

Two-requester Membus arbiter with pipelined issue: shares one RAM port between the CPU and DMA masters while allowing up to MAX_OUT requests in flight. Responses are routed back in order via a source-tag FIFO. The CPU has fixed priority; an optional starvation guard bounds DMA wait time. Sits between the core/DMA bus masters and the RAM controller.

## Interface
- MAX_OUT, 2: maximum outstanding requests (1..8); sets the tag FIFO depth.
- STARVE_LIMIT, 8: consecutive blocked DMA cycles before DMA is promoted (guard build only).
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- cpu  Membus.slave  —  CPU request/response port (valid, ready, addr, wen, wdata, wmask, rvalid, rdata).
- dma  Membus.slave  —  DMA request/response port.
- out  Membus.master  —  shared RAM port.
- spurious  out  1  sticky flag: out.rvalid arrived with no request outstanding.

## Operation
- Issue is combinational pass-through. The selected source's addr/wen/wdata/wmask drive out; out.valid = selected valid & !full.
- The selected source's ready = out.ready & !full. The unselected source's ready = 0.
- Selection when unlocked: CPU if cpu.valid, else DMA.
- Lock: if out.valid & !out.ready, register lock = 1 and lock_src = the current source. While locked, the same source stays selected regardless of priority. Lock clears on the fire cycle.
- Every fire (out.valid & out.ready) pushes the source tag (SRC_CPU/SRC_DMA) into the FIFO. Reads and writes are both tracked, since RAM returns rvalid for both.
- out.rvalid pops the FIFO head and routes it:
  - the head's rvalid = 1 and its rdata = out.rdata;
  - the other port's rvalid = 0 and its rdata = 0.
- out.rvalid with the FIFO empty: response dropped, spurious set to 1, held until reset.
- Full (count == MAX_OUT): no issue; out.valid = 0.
  - A same-cycle pop does not unblock issue (full is registered count only).
  - Lock is retained while full.
- Simultaneous push and pop: count unchanged; the FIFO stays in order.
- Idle defaults: out.addr, wen, wdata and wmask = 0 when nothing is selected.

## Timing
- Request latency: 0 cycles. Grant and ready are combinational in the same cycle as valid.
- Response latency: 0 cycles added; cpu/dma.rvalid follows out.rvalid combinationally.
- Throughput: one fire per cycle while not full.
- Reset values:
  - count = 0, FIFO pointers = 0, lock = 0, starve counter = 0, spurious = 0;
  - all outputs 0 (out.valid, cpu.ready, dma.ready, both rvalid).
- Reset mid-operation drops all outstanding tags. The downstream RAM must be reset in the same domain.
- Pointers wrap modulo MAX_OUT. Count width is $clog2(MAX_OUT+1).

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - the starve counter increments each cycle dma.valid & !dma fire, saturating at STARVE_LIMIT, and clears on a DMA fire;
  - at STARVE_LIMIT, unlocked selection prefers DMA over CPU until that DMA request fires.
- Undefined: pure CPU priority, no counter logic, and the STARVE_LIMIT parameter is ignored.

## Structure
- Shared package membus_arb_pkg holds:
  - typedef enum logic {SRC_CPU, SRC_DMA} src_t;
  - localparam MAX_OUT_LIMIT = 8.
- Sub-module arb_tag_fifo: parameterised depth, src_t payload, push/pop/full/empty/count, async active-high reset.
- Top level holds the select/lock logic, the optional starve counter and response routing.

## Test plan
- Contention: CPU and DMA valid together, out.ready = 1 → CPU fires. With cpu.valid held, DMA never fires (guard off). After a response, only cpu.rvalid = 1 with rdata = 0xDEADBEEF.
- Lock under backpressure: DMA valid alone with out.ready = 0 for 3 cycles, CPU raises valid in cycle 2 → out stays driven by the DMA addr (0x100) until fire; CPU fires next cycle.
- Pipelining, MAX_OUT = 2: CPU read A, DMA read B on consecutive cycles, RAM latency 2, a third request blocked while full → responses arrive in order: cpu.rvalid then dma.rvalid; the third request fires the cycle after the first pop.
- Starvation guard (ARB_STARVE_GUARD_EN, STARVE_LIMIT = 4): CPU valid continuously, DMA valid from cycle 0 → DMA fires on cycle 4; counter returns to 0.
- Spurious response: out.rvalid pulsed with count = 0 → no port rvalid; spurious = 1 and stays 1 until rst.
- Reset mid-flight: 2 requests outstanding, rst asserted → all outputs 0 immediately; after release count = 0 and a new CPU request fires in the first cycle.
